// File: rtl/pokey_pkg.sv
// Shared POKEY definitions: AUDCTL bit positions and default reload offsets
// for the channel dividers.
package pokey_pkg;

  localparam int AC_CH1FAST = 6;
  localparam int AC_CH3FAST = 5;
  localparam int AC_J12     = 4;
  localparam int AC_J34     = 3;

  localparam int OFS8_DEF  = 3;
  localparam int OFS16_DEF = 6;

endpackage

// File: rtl/aud_div_pair.sv
// One low/high audio channel pair: two 9-bit dividers, or a single 17-bit
// divider when joined, with fast-source reload offsets and underflow pulses.
module aud_div_pair
  import pokey_pkg::*;
#(
  parameter int OFS8  = OFS8_DEF,
  parameter int OFS16 = OFS16_DEF
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       cpuClk,
  input  logic       audClock,
  input  logic       fast,
  input  logic       join_en,
  input  logic       load,
  input  logic       init,
  input  logic [7:0] audf_lo,
  input  logic [7:0] audf_hi,
  output logic [1:0] pulse
);

  logic [8:0]  cnt_lo_q, cnt_lo_d;
  logic [8:0]  cnt_hi_q, cnt_hi_d;
  logic [16:0] cnt_j_q, cnt_j_d;
  logic [1:0]  pulse_q, pulse_d;

  logic [8:0]  rel_lo, rel_hi;
  logic [16:0] rel_j;
  logic        tick_lo, tick_hi;

  // Reload sums are widened before the add so 255+OFS8 and 65535+OFS16 never wrap.
  assign rel_lo  = {1'b0, audf_lo} + (fast ? 9'(OFS8) : 9'd0);
  assign rel_hi  = {1'b0, audf_hi};
  assign rel_j   = {1'b0, audf_hi, audf_lo} + (fast ? 17'(OFS16) : 17'd0);
  assign tick_lo = cpuClk & (fast | audClock);
  assign tick_hi = cpuClk & audClock;

  always_comb begin
    cnt_lo_d = cnt_lo_q;
    cnt_hi_d = cnt_hi_q;
    cnt_j_d  = cnt_j_q;
    pulse_d  = 2'b00;
    if (init) begin
      if (cpuClk) begin
        cnt_lo_d = rel_lo;
        cnt_hi_d = rel_hi;
        cnt_j_d  = rel_j;
      end
    end else if (load) begin
      cnt_lo_d = rel_lo;
      cnt_hi_d = rel_hi;
      cnt_j_d  = rel_j;
    end else if (join_en) begin
      // Joined pair runs on the low channel's source; only the high bit pulses.
      if (tick_lo) begin
        if (cnt_j_q == 17'd0) begin
          cnt_j_d    = rel_j;
          pulse_d[1] = 1'b1;
        end else begin
          cnt_j_d = cnt_j_q - 17'd1;
        end
      end
    end else begin
      if (tick_lo) begin
        if (cnt_lo_q == 9'd0) begin
          cnt_lo_d   = rel_lo;
          pulse_d[0] = 1'b1;
        end else begin
          cnt_lo_d = cnt_lo_q - 9'd1;
        end
      end
      if (tick_hi) begin
        if (cnt_hi_q == 9'd0) begin
          cnt_hi_d   = rel_hi;
          pulse_d[1] = 1'b1;
        end else begin
          cnt_hi_d = cnt_hi_q - 9'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      cnt_lo_q <= '0;
      cnt_hi_q <= '0;
      cnt_j_q  <= '0;
      pulse_q  <= '0;
    end else begin
      cnt_lo_q <= cnt_lo_d;
      cnt_hi_q <= cnt_hi_d;
      cnt_j_q  <= cnt_j_d;
      pulse_q  <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/aud_chan_sched.sv
// Audio channel clock scheduler: two divider pairs plus the STIMER pending
// flag and per-pair join-change detection that force aligned reloads.
module aud_chan_sched
  import pokey_pkg::*;
#(
  parameter int OFS8  = OFS8_DEF,
  parameter int OFS16 = OFS16_DEF
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       cpuClk,
  input  logic       audClock,
  input  logic       init,
  input  logic       stimer,
  input  logic [7:0] audctl,
  input  logic [7:0] audf1,
  input  logic [7:0] audf2,
  input  logic [7:0] audf3,
  input  logic [7:0] audf4,
  output logic [3:0] chanOut
);

  logic       st_pend_q, st_pend_d;
  logic [1:0] jp_q, jp_d;
  logic [1:0] join_q, join_d;
  logic [1:0] join_now;
  logic [1:0] chg;
  logic [1:0] ld;
  logic [1:0] p12, p34;
  logic       unused_audctl;

  assign join_now      = {audctl[AC_J34], audctl[AC_J12]};
  assign chg           = join_now ^ join_q;
  assign unused_audctl = ^{audctl[7], audctl[2:0]};

  // A pending request (or one arriving on this very clk) is served by the
  // next cpuClk; STIMER and a join change in the same window merge into one reload.
  assign ld[0] = cpuClk & (st_pend_q | stimer | jp_q[0] | chg[0]);
  assign ld[1] = cpuClk & (st_pend_q | stimer | jp_q[1] | chg[1]);

  always_comb begin
    st_pend_d = st_pend_q | stimer;
    jp_d      = jp_q | chg;
    join_d    = join_now;
    if (init || cpuClk) begin
      st_pend_d = 1'b0;
      jp_d      = 2'b00;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      st_pend_q <= 1'b0;
      jp_q      <= 2'b00;
      join_q    <= 2'b00;
    end else begin
      st_pend_q <= st_pend_d;
      jp_q      <= jp_d;
      join_q    <= join_d;
    end
  end

  aud_div_pair #(.OFS8(OFS8), .OFS16(OFS16)) u_pair12 (
    .clk      (clk),
    .resetN   (resetN),
    .cpuClk   (cpuClk),
    .audClock (audClock),
    .fast     (audctl[AC_CH1FAST]),
    .join_en  (audctl[AC_J12]),
    .load     (ld[0]),
    .init     (init),
    .audf_lo  (audf1),
    .audf_hi  (audf2),
    .pulse    (p12)
  );

  aud_div_pair #(.OFS8(OFS8), .OFS16(OFS16)) u_pair34 (
    .clk      (clk),
    .resetN   (resetN),
    .cpuClk   (cpuClk),
    .audClock (audClock),
    .fast     (audctl[AC_CH3FAST]),
    .join_en  (audctl[AC_J34]),
    .load     (ld[1]),
    .init     (init),
    .audf_lo  (audf3),
    .audf_hi  (audf4),
    .pulse    (p34)
  );

  assign chanOut = {p34, p12};

endmodule

// File: tb/tb_aud_chan_sched.sv
// Directed bench for aud_chan_sched: pulse spacing, join, STIMER and reset
// behaviour, with every expected value worked out by hand.
module tb_aud_chan_sched;

  logic       clk;
  logic       resetN;
  logic       cpuClk;
  logic       audClock;
  logic       init;
  logic       stimer;
  logic [7:0] audctl;
  logic [7:0] audf1, audf2, audf3, audf4;
  logic [3:0] chanOut;

  int   n_tests;
  int   n_fail;
  int   aud_per;
  int   aud_cnt;
  logic last_aud;
  int   tnow;
  int   pcnt[4];
  int   last_t[4];
  int   prev_t[4];

  aud_chan_sched dut (
    .clk      (clk),
    .resetN   (resetN),
    .cpuClk   (cpuClk),
    .audClock (audClock),
    .init     (init),
    .stimer   (stimer),
    .audctl   (audctl),
    .audf1    (audf1),
    .audf2    (audf2),
    .audf3    (audf3),
    .audf4    (audf4),
    .chanOut  (chanOut)
  );

  // ---------------- clock / watchdog ----------------
  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checker ----------------
  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic clr_stats();
    for (int i = 0; i < 4; i++) begin
      pcnt[i]   = 0;
      last_t[i] = -1;
      prev_t[i] = -1;
    end
    tnow = 0;
  endtask

  // One 1.79 MHz cycle: a clk with cpuClk high, then a clk with it low.
  // chanOut is sampled at the second negedge, one clk after the enable.
  task automatic cyc(input logic st);
    logic a;
    a = 1'b0;
    if (aud_per != 0) begin
      if (aud_cnt == aud_per - 1) begin
        a       = 1'b1;
        aud_cnt = 0;
      end else begin
        aud_cnt++;
      end
    end
    @(negedge clk);
    cpuClk   = 1'b1;
    audClock = a;
    stimer   = st;
    @(negedge clk);
    cpuClk   = 1'b0;
    audClock = 1'b0;
    stimer   = 1'b0;
    last_aud = a;
    for (int i = 0; i < 4; i++) begin
      if (chanOut[i]) begin
        prev_t[i] = last_t[i];
        last_t[i] = tnow;
        pcnt[i]++;
      end
    end
    tnow++;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int   ticks;
    logic found;
    logic [3:0] seen;

    n_tests  = 0;
    n_fail   = 0;
    resetN   = 1'b0;
    cpuClk   = 1'b0;
    audClock = 1'b0;
    init     = 1'b0;
    stimer   = 1'b0;
    audctl   = 8'h60;
    audf1    = 8'd3;
    audf2    = 8'hFF;
    audf3    = 8'hFF;
    audf4    = 8'hFF;
    aud_per  = 1;
    aud_cnt  = 0;
    last_aud = 1'b0;
    clr_stats();

    repeat (5) @(negedge clk);
    check("rst_out", int'(chanOut), 0);

    // init holds everything quiet even with ticks on every cpuClk
    resetN = 1'b1;
    init   = 1'b1;
    clr_stats();
    repeat (20) cyc(1'b0);
    check("init_pulses", pcnt[0] + pcnt[1] + pcnt[2] + pcnt[3], 0);
    init = 1'b0;

    // base clock: AUDF=3 -> 4 ticks of 28 cpuClk
    audctl  = 8'h00;
    aud_per = 28;
    aud_cnt = 0;
    clr_stats();
    repeat (400) cyc(1'b0);
    check("base_cnt", pcnt[0], 2);
    check("base_per", last_t[0] - prev_t[0], 112);

    // fast 8-bit: AUDF+4
    audctl  = 8'h40;
    audf1   = 8'd0;
    aud_per = 0;
    clr_stats();
    repeat (20) cyc(1'b0);
    check("fast0_per", last_t[0] - prev_t[0], 4);

    audf1 = 8'd255;
    clr_stats();
    repeat (600) cyc(1'b0);
    check("fast255_per", last_t[0] - prev_t[0], 259);

    // joined fast: AUDF16=256 -> 263, low bit silent
    audf1  = 8'h00;
    audf2  = 8'h01;
    audctl = 8'h50;
    clr_stats();
    repeat (600) cyc(1'b0);
    check("join_lo_silent", pcnt[0], 0);
    check("join_hi_cnt", pcnt[1], 2);
    check("join_hi_per", last_t[1] - prev_t[1], 263);

    // desynchronise the four channels, then align them with STIMER
    audf1   = 8'd2;
    audf2   = 8'd5;
    audf3   = 8'd7;
    audf4   = 8'd9;
    audctl  = 8'h00;
    aud_per = 4;
    aud_cnt = 0;
    repeat (100) cyc(1'b0);
    audf1   = 8'd9;
    audf2   = 8'd9;
    audf3   = 8'd9;
    audf4   = 8'd9;
    aud_per = 28;
    aud_cnt = 27;
    cyc(1'b1);
    check("stim_nopulse", int'(chanOut), 0);
    ticks = 0;
    found = 1'b0;
    seen  = 4'd0;
    for (int k = 0; k < 400 && !found; k++) begin
      cyc(1'b0);
      ticks += int'(last_aud);
      if (chanOut != 4'd0) begin
        found = 1'b1;
        seen  = chanOut;
      end
    end
    check("stim_found", int'(found), 1);
    check("stim_all4", int'(seen), 15);
    check("stim_ticks", ticks, 10);

    // join ch3/4 mid-count: AUDF16={0,9}=9 -> pulse on the 10th tick
    repeat (60) cyc(1'b0);
    audf3   = 8'd9;
    audf4   = 8'd0;
    audctl  = 8'h08;
    aud_cnt = 27;
    clr_stats();
    cyc(1'b0);
    check("jtog_nopulse", int'(chanOut[3:2]), 0);
    ticks = 0;
    found = 1'b0;
    for (int k = 0; k < 400 && !found; k++) begin
      cyc(1'b0);
      ticks += int'(last_aud);
      if (chanOut[3]) found = 1'b1;
    end
    check("jtog_found", int'(found), 1);
    check("jtog_ticks", ticks, 10);
    check("jtog_lo_silent", pcnt[2], 0);

    // reset mid-count: silence, then first tick underflows at once
    audctl  = 8'h40;
    audf1   = 8'd0;
    aud_per = 0;
    repeat (10) cyc(1'b0);
    resetN = 1'b0;
    clr_stats();
    repeat (8) cyc(1'b0);
    check("rst_mid_pulses", pcnt[0] + pcnt[1] + pcnt[2] + pcnt[3], 0);
    resetN = 1'b1;
    cyc(1'b0);
    check("rst_first", int'(chanOut), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
